// File: rtl/t81_opcode_sequencer.sv
// Opcode issue sequencer for mining_pipeline: replays a stored (opcode, operand) program,
// then starts a mining pass and waits for a match with timeout and nonce-increment retries.
module t81_opcode_sequencer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GAP       = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned MAX_RETRY = 0,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_opcode,
  input  logic [80:0]   wr_operand,
  input  logic [AW:0]   prog_len,
  input  logic          nonce_en,
  input  logic          go,
  input  logic          abort,
  output logic [7:0]    opcode,
  output logic [80:0]   operand,
  output logic          valid_opcode,
  output logic          start_mine,
  input  logic          match_found,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic          err,
  output logic [31:0]   nonce,
  output logic [31:0]   cycle_count
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGap,
    StMine,
    StWait,
    StDone
  } state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [AW:0]   prog_len_q;
  logic          nonce_en_q;
  logic [GW-1:0] gap_cnt_q;

  logic [7:0]    mem_op   [DEPTH];
  logic [80:0]   mem_opnd [DEPTH];

  logic [AW-1:0] idx_inc;
  logic          idx_is_last;
  logic          inc_is_last;
  logic          advance;
  logic          retry_left;
  logic          wait_expired;
  logic [31:0]   nonce_inc;
  logic [31:0]   cycle_inc;
  logic [80:0]   adv_operand;
  logic [80:0]   retry_operand;

  // Program store; contents survive reset and are frozen while a sequence runs.
  always_ff @(posedge clk) begin
    if (wr_en && state_q == StIdle) begin
      mem_op[wr_addr]   <= wr_opcode;
      mem_opnd[wr_addr] <= wr_operand;
    end
  end

  always_comb begin
    idx_inc      = idx_q + AW'(1);
    idx_is_last  = ({1'b0, idx_q} + (AW+1)'(1)) == prog_len_q;
    inc_is_last  = ({1'b0, idx_inc} + (AW+1)'(1)) == prog_len_q;
    advance      = (state_q == StIssue && GAP == 0) || (state_q == StGap && gap_cnt_q == '0);
    retry_left   = nonce < MAX_RETRY;
    wait_expired = cycle_count == TIMEOUT - 1;
    nonce_inc    = (nonce == '1) ? nonce : nonce + 32'd1;
    cycle_inc    = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
    // Only the last program entry carries the pass nonce.
    adv_operand   = mem_opnd[idx_inc] +
                    ((nonce_en_q && inc_is_last) ? {49'd0, nonce} : 81'd0);
    retry_operand = mem_opnd[0] +
                    ((nonce_en_q && prog_len_q == (AW+1)'(1)) ? {49'd0, nonce_inc} : 81'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      prog_len_q   <= '0;
      nonce_en_q   <= 1'b0;
      gap_cnt_q    <= '0;
      opcode       <= '0;
      operand      <= '0;
      valid_opcode <= 1'b0;
      start_mine   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timed_out    <= 1'b0;
      err          <= 1'b0;
      nonce        <= '0;
      cycle_count  <= '0;
    end else begin
      valid_opcode <= 1'b0;
      start_mine   <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (go) begin
              if (prog_len > (AW+1)'(DEPTH)) begin
                err <= 1'b1;
              end else begin
                prog_len_q <= prog_len;
                nonce_en_q <= nonce_en;
                nonce      <= '0;
                timed_out  <= 1'b0;
                busy       <= 1'b1;
                idx_q      <= '0;
                if (prog_len == '0) begin
                  state_q     <= StMine;
                  start_mine  <= 1'b1;
                  cycle_count <= '0;
                end else begin
                  state_q      <= StIssue;
                  valid_opcode <= 1'b1;
                  opcode       <= mem_op[0];
                  operand      <= mem_opnd[0];
                end
              end
            end
          end
          StIssue, StGap: begin
            if (advance) begin
              if (idx_is_last) begin
                state_q     <= StMine;
                start_mine  <= 1'b1;
                cycle_count <= '0;
              end else begin
                state_q      <= StIssue;
                valid_opcode <= 1'b1;
                idx_q        <= idx_inc;
                opcode       <= mem_op[idx_inc];
                operand      <= adv_operand;
              end
            end else if (state_q == StIssue) begin
              state_q   <= StGap;
              gap_cnt_q <= GW'(GAP - 1);
            end else begin
              gap_cnt_q <= gap_cnt_q - GW'(1);
            end
          end
          StMine: begin
            state_q <= StWait;
          end
          StWait: begin
            // A match on the last allowed cycle beats the timeout.
            if (match_found) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else if (wait_expired) begin
              if (retry_left) begin
                nonce <= nonce_inc;
                idx_q <= '0;
                if (prog_len_q == '0) begin
                  state_q     <= StMine;
                  start_mine  <= 1'b1;
                  cycle_count <= '0;
                end else begin
                  state_q      <= StIssue;
                  valid_opcode <= 1'b1;
                  opcode       <= mem_op[0];
                  operand      <= retry_operand;
                end
              end else begin
                timed_out <= 1'b1;
                state_q   <= StDone;
                done      <= 1'b1;
              end
            end else begin
              cycle_count <= cycle_inc;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t81_opcode_sequencer.sv
// Randomized self-checking bench for t81_opcode_sequencer against a timeline-building model.
module tb_t81_opcode_sequencer;

  localparam int DEPTH     = 8;
  localparam int GAP       = 2;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 2;
  localparam int MAXN      = 160;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [2:0]   wr_addr;
  logic [7:0]   wr_opcode;
  logic [80:0]  wr_operand;
  logic [3:0]   prog_len;
  logic         nonce_en;
  logic         go;
  logic         abort;
  logic [7:0]   opcode;
  logic [80:0]  operand;
  logic         valid_opcode;
  logic         start_mine;
  logic         match_found;
  logic         busy;
  logic         done;
  logic         timed_out;
  logic         err;
  logic [31:0]  nonce;
  logic [31:0]  cycle_count;

  int checks = 0;
  int errors = 0;

  // Reference program and per-cycle stimulus / expectations.
  logic [7:0]  ref_op   [DEPTH];
  logic [80:0] ref_opnd [DEPTH];
  bit          match_at [MAXN];
  bit          abort_at [MAXN];
  logic [3:0]  e_stat   [MAXN];
  logic [7:0]  e_op     [MAXN];
  logic [80:0] e_opnd   [MAXN];
  logic [3:0]  cap_stat [MAXN];
  logic [7:0]  cap_op   [MAXN];
  logic [80:0] cap_opnd [MAXN];
  bit          m_to;
  int          m_cc;
  int          m_nonce;

  t81_opcode_sequencer #(
    .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_opcode(wr_opcode),
    .wr_operand(wr_operand), .prog_len(prog_len), .nonce_en(nonce_en), .go(go),
    .abort(abort), .opcode(opcode), .operand(operand), .valid_opcode(valid_opcode),
    .start_mine(start_mine), .match_found(match_found), .busy(busy), .done(done),
    .timed_out(timed_out), .err(err), .nonce(nonce), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_entry(input int a, input logic [7:0] op, input logic [80:0] v,
                             input bit track);
    wr_en = 1'b1; wr_addr = 3'(a); wr_opcode = op; wr_operand = v;
    tick(1);
    wr_en = 1'b0;
    if (track) begin
      ref_op[a] = op;
      ref_opnd[a] = v;
    end
  endtask

  task automatic clear_stim();
    for (int j = 0; j < MAXN; j++) begin
      match_at[j] = 1'b0;
      abort_at[j] = 1'b0;
    end
  endtask

  task automatic start_go(input int len, input bit nen);
    prog_len = 4'(len); nonce_en = nen; go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  // Index j holds the outputs of the j-th cycle after the go edge.
  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      cap_stat[j] = {valid_opcode, start_mine, done, busy};
      cap_op[j] = opcode;
      cap_opnd[j] = operand;
      match_found = match_at[j];
      abort = abort_at[j];
      tick(1);
    end
    match_found = 1'b0;
    abort = 1'b0;
  endtask

  // Lays out the expected timeline pass by pass: entries every GAP+1 cycles, one mine
  // cycle, then up to TIMEOUT wait cycles, then a single done cycle.
  task automatic model_run(input int len, input bit nen);
    int j = 0;
    int pass = 0;
    bit fin = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      e_stat[i] = 4'b0; e_op[i] = 8'h0; e_opnd[i] = 81'h0;
    end
    m_to = 1'b0; m_cc = 0; m_nonce = 0;
    while (!fin) begin
      m_nonce = pass;
      for (int e = 0; e < len; e++) begin
        if (j < MAXN) begin
          e_stat[j] = 4'b1001;
          e_op[j] = ref_op[e];
          e_opnd[j] = ref_opnd[e] + ((nen && e == len - 1) ? 81'(pass) : 81'd0);
        end
        for (int g = 1; g <= GAP; g++) if (j + g < MAXN) e_stat[j+g] = 4'b0001;
        j += GAP + 1;
      end
      if (j < MAXN) e_stat[j] = 4'b0101;
      j++;
      for (int w = 0; w < TIMEOUT && !fin; w++) begin
        if (j < MAXN) e_stat[j] = 4'b0001;
        m_cc = w;
        if (j < MAXN && match_at[j]) fin = 1'b1;
        j++;
      end
      if (!fin) begin
        if (pass < MAX_RETRY) pass++;
        else begin
          m_to = 1'b1;
          fin = 1'b1;
        end
      end
    end
    if (j < MAXN) e_stat[j] = 4'b0011;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_opcode = '0; wr_operand = '0;
    prog_len = '0; nonce_en = 1'b0; go = 1'b0; abort = 1'b0; match_found = 1'b0;
    tick(2);
    checks++;
    if ({valid_opcode, start_mine, busy, done, timed_out, err} !== 6'b0 ||
        nonce !== 32'd0 || cycle_count !== 32'd0 || opcode !== 8'h0 || operand !== 81'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b valid=%b nonce=%0d cc=%0d, want all 0",
               busy, valid_opcode, nonce, cycle_count);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b err=%b, want 0 0", busy, err);
    end
  endtask

  task automatic test_program();
    write_entry(0, 8'h01, 81'd1, 1'b1);
    write_entry(1, 8'h01, 81'd2, 1'b1);
    write_entry(2, 8'h01, 81'd3, 1'b1);
    write_entry(3, 8'h03, 81'd0, 1'b1);
    clear_stim();
    match_at[18] = 1'b1;
    model_run(4, 1'b0);
    start_go(4, 1'b0);
    capture(22);
    for (int j = 0; j < 22; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j]) begin
        errors++;
        $display("FAIL prog_stat cyc %0d got %b want %b", j, cap_stat[j], e_stat[j]);
      end
      if (e_stat[j][3]) begin
        checks++;
        if (cap_op[j] !== e_op[j] || cap_opnd[j] !== e_opnd[j]) begin
          errors++;
          $display("FAIL prog_entry cyc %0d got %h:%h want %h:%h", j, cap_op[j], cap_opnd[j],
                   e_op[j], e_opnd[j]);
        end
      end
    end
    checks++;
    if (cap_op[1] !== 8'h01 || cap_opnd[1] !== 81'd1) begin
      errors++;
      $display("FAIL prog_hold got %h:%h want 01:1", cap_op[1], cap_opnd[1]);
    end
    checks++;
    if (cycle_count !== 32'd5 || timed_out !== 1'b0 || nonce !== 32'd0) begin
      errors++;
      $display("FAIL prog_final got cc=%0d to=%b nonce=%0d want 5 0 0",
               cycle_count, timed_out, nonce);
    end
  endtask

  task automatic test_reset_mid_wait();
    start_go(1, 1'b0);
    tick(7);
    checks++;
    if (cycle_count !== 32'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midwait_pre got cc=%0d busy=%b want 3 1", cycle_count, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_opcode, start_mine, busy, done, timed_out, err} !== 6'b0 ||
        nonce !== 32'd0 || cycle_count !== 32'd0 || opcode !== 8'h0 || operand !== 81'h0) begin
      errors++;
      $display("FAIL midwait_reset got busy=%b cc=%0d op=%h want all 0", busy, cycle_count, opcode);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_retry();
    write_entry(0, 8'($urandom()), {17'($urandom()), $urandom(), $urandom()}, 1'b1);
    write_entry(1, 8'h05, 81'h10, 1'b1);
    clear_stim();
    model_run(2, 1'b1);
    start_go(2, 1'b1);
    capture(72);
    for (int j = 0; j < 72; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j]) begin
        errors++;
        $display("FAIL retry_stat cyc %0d got %b want %b", j, cap_stat[j], e_stat[j]);
      end
      if (e_stat[j][3]) begin
        checks++;
        if (cap_op[j] !== e_op[j] || cap_opnd[j] !== e_opnd[j]) begin
          errors++;
          $display("FAIL retry_entry cyc %0d got %h:%h want %h:%h", j, cap_op[j], cap_opnd[j],
                   e_op[j], e_opnd[j]);
        end
      end
    end
    checks++;
    if (cap_opnd[3] !== 81'h10 || cap_opnd[26] !== 81'h11 || cap_opnd[49] !== 81'h12) begin
      errors++;
      $display("FAIL retry_nonce_opnd got %h %h %h want 10 11 12",
               cap_opnd[3], cap_opnd[26], cap_opnd[49]);
    end
    checks++;
    if (timed_out !== 1'b1 || nonce !== 32'd2 || cycle_count !== 32'(TIMEOUT - 1)) begin
      errors++;
      $display("FAIL retry_final got to=%b nonce=%0d cc=%0d want 1 2 %0d",
               timed_out, nonce, cycle_count, TIMEOUT - 1);
    end
  endtask

  task automatic test_len_edges();
    clear_stim();
    match_at[5] = 1'b1;
    model_run(0, 1'b0);
    start_go(0, 1'b0);
    capture(10);
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j]) begin
        errors++;
        $display("FAIL len0_stat cyc %0d got %b want %b", j, cap_stat[j], e_stat[j]);
      end
    end
    checks++;
    if (cycle_count !== 32'd4 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL len0_final got cc=%0d to=%b want 4 0", cycle_count, timed_out);
    end
    start_go(DEPTH + 1, 1'b0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || valid_opcode !== 1'b0 || start_mine !== 1'b0) begin
      errors++;
      $display("FAIL overlen_err got err=%b busy=%b want 1 0", err, busy);
    end
    tick(1);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL overlen_after got err=%b busy=%b want 0 0", err, busy);
    end
  endtask

  task automatic test_abort();
    int k;
    for (int a = 0; a < 3; a++)
      write_entry(a, 8'($urandom()), {17'($urandom()), $urandom(), $urandom()}, 1'b1);
    clear_stim();
    abort_at[4] = 1'b1;
    model_run(3, 1'b0);
    for (int j = 5; j < MAXN; j++) e_stat[j] = 4'b0;
    start_go(3, 1'b0);
    capture(20);
    for (int j = 0; j < 20; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j]) begin
        errors++;
        $display("FAIL abort_stat cyc %0d got %b want %b", j, cap_stat[j], e_stat[j]);
      end
    end
    // Writes and an illegal go while busy must both be ignored.
    start_go(3, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd0; wr_opcode = ~ref_op[0]; wr_operand = ~ref_opnd[0];
    prog_len = 4'd15; go = 1'b1;
    tick(1);
    wr_en = 1'b0; go = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_go got err=%b busy=%b want 0 1", err, busy);
    end
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_drain got busy=%b after %0d cycles want 0", busy, k);
    end
    clear_stim();
    match_at[12] = 1'b1;
    model_run(3, 1'b0);
    start_go(3, 1'b0);
    capture(16);
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j] ||
          (e_stat[j][3] && (cap_op[j] !== e_op[j] || cap_opnd[j] !== e_opnd[j]))) begin
        errors++;
        $display("FAIL replay cyc %0d got %b %h:%h want %b %h:%h", j, cap_stat[j], cap_op[j],
                 cap_opnd[j], e_stat[j], e_op[j], e_opnd[j]);
      end
    end
  endtask

  task automatic test_match_boundary();
    clear_stim();
    match_at[0] = 1'b1;
    match_at[3] = 1'b1;
    match_at[19] = 1'b1;
    model_run(1, 1'b0);
    start_go(1, 1'b0);
    capture(24);
    for (int j = 0; j < 24; j++) begin
      checks++;
      if (cap_stat[j] !== e_stat[j]) begin
        errors++;
        $display("FAIL bound_stat cyc %0d got %b want %b", j, cap_stat[j], e_stat[j]);
      end
    end
    checks++;
    if (cycle_count !== 32'(TIMEOUT - 1) || timed_out !== 1'b0 || nonce !== 32'd0) begin
      errors++;
      $display("FAIL bound_final got cc=%0d to=%b nonce=%0d want %0d 0 0",
               cycle_count, timed_out, nonce, TIMEOUT - 1);
    end
  endtask

  task automatic test_random();
    int len;
    bit nen;
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < DEPTH; a++)
        write_entry(a, 8'($urandom()), {17'($urandom()), $urandom(), $urandom()}, 1'b1);
      len = int'($urandom_range(1, DEPTH));
      nen = 1'($urandom_range(0, 1));
      clear_stim();
      if ($urandom_range(0, 3) != 0) match_at[$urandom_range(0, 125)] = 1'b1;
      match_at[$urandom_range(0, 8)] = 1'b1;
      model_run(len, nen);
      start_go(len, nen);
      capture(126);
      for (int j = 0; j < 126; j++) begin
        checks++;
        if (cap_stat[j] !== e_stat[j] ||
            (e_stat[j][3] && (cap_op[j] !== e_op[j] || cap_opnd[j] !== e_opnd[j]))) begin
          errors++;
          $display("FAIL rand%0d cyc %0d got %b %h:%h want %b %h:%h", it, j, cap_stat[j],
                   cap_op[j], cap_opnd[j], e_stat[j], e_op[j], e_opnd[j]);
        end
      end
      checks++;
      if (timed_out !== m_to || nonce !== 32'(m_nonce) || cycle_count !== 32'(m_cc)) begin
        errors++;
        $display("FAIL rand%0d_final got to=%b nonce=%0d cc=%0d want %b %0d %0d", it,
                 timed_out, nonce, cycle_count, m_to, m_nonce, m_cc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_reset_mid_wait();
    test_retry();
    test_len_edges();
    test_abort();
    test_match_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
